// File: rtl/icon_pkg.sv
// Shared types and constants for the bot icon update scheduler.
package icon_pkg;
    localparam int ROW_W          = 10;
    localparam int COORD_W        = 8;
    localparam int DISP_W         = 640;
    localparam int DISP_H         = 480;
    localparam int COMMIT_ROW_DEF = DISP_H;

    localparam int ORIENT_MSB = 2;
    localparam int ORIENT_LSB = 0;
    localparam int ALERT_BIT  = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } icon_state_t;

    function automatic logic info_alert(input logic [COORD_W-1:0] info);
        return info[ALERT_BIT];
    endfunction

    function automatic logic [ORIENT_MSB-ORIENT_LSB:0] info_orient(input logic [COORD_W-1:0] info);
        return info[ORIENT_MSB:ORIENT_LSB];
    endfunction
endpackage

// File: rtl/icon_ctrl_frame_strobe.sv
// Frame boundary detector: one-clock frameTick after the commit point is first
// seen (robust to several clocks per pixel), plus a wrapping frame counter.
module frame_strobe
    import icon_pkg::*;
#(
    parameter int COMMIT_ROW = COMMIT_ROW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] i_row,
    input  logic [ROW_W-1:0] i_col,
    output logic             o_tick,
    output logic [7:0]       o_count
);
    logic w_cond;
    logic r_cond_d;
    logic r_tick;
    logic [7:0] r_count;

    assign w_cond = (i_row == ROW_W'(COMMIT_ROW)) && (i_col == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond_d <= 1'b0;
            r_tick   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_cond_d <= w_cond;
            r_tick   <= w_cond && !r_cond_d;
            if (r_tick)
                r_count <= r_count + 8'd1;
        end
    end

    assign o_tick  = r_tick;
    assign o_count = r_count;
endmodule

// File: rtl/icon_ctrl.sv
// Bot icon update scheduler: shadows processor updates and commits them to the
// live icon registers only at the vertical-blanking frame boundary.
// Optional blink of iconEnable on alert is enabled by defining ICON_BLINK_EN.
module icon_ctrl
    import icon_pkg::*;
#(
    parameter int COMMIT_ROW   = COMMIT_ROW_DEF,
    parameter int OVERWRITE    = 1,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROW_W-1:0]     pixRow,
    input  logic [ROW_W-1:0]     pixCol,
    input  logic                 updValid,
    output logic                 updReady,
    input  logic [COORD_W-1:0]   newLocX,
    input  logic [COORD_W-1:0]   newLocY,
    input  logic [COORD_W-1:0]   newBotInfo,
    output logic [COORD_W-1:0]   locX,
    output logic [COORD_W-1:0]   locY,
    output logic [COORD_W-1:0]   botInfo,
    output logic                 iconEnable,
    output logic                 frameTick,
    output logic [7:0]           frameCount,
    output logic                 pending
);
    localparam logic OVW = (OVERWRITE != 0);

    icon_state_t        r_state;
    logic               r_upd_ready;
    logic [COORD_W-1:0] r_sh_x, r_sh_y, r_sh_info;
    logic [COORD_W-1:0] r_loc_x, r_loc_y, r_bot_info;
    logic               r_icon_en;
    logic               w_tick;
    logic               w_xfer;
    logic               w_commit;

    frame_strobe #(.COMMIT_ROW(COMMIT_ROW)) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .i_row   (pixRow),
        .i_col   (pixCol),
        .o_tick  (w_tick),
        .o_count (frameCount)
    );

    assign w_xfer   = updValid && r_upd_ready;
    assign w_commit = (r_state == PENDING) && w_tick;

    // Commit reads the shadow before a same-edge transfer overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_upd_ready <= 1'b1;
            r_sh_x      <= '0;
            r_sh_y      <= '0;
            r_sh_info   <= '0;
            r_loc_x     <= '0;
            r_loc_y     <= '0;
            r_bot_info  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_sh_x      <= newLocX;
                        r_sh_y      <= newLocY;
                        r_sh_info   <= newBotInfo;
                        r_state     <= PENDING;
                        r_upd_ready <= OVW;
                    end
                end
                PENDING: begin
                    if (w_tick) begin
                        r_loc_x    <= r_sh_x;
                        r_loc_y    <= r_sh_y;
                        r_bot_info <= r_sh_info;
                    end
                    if (w_xfer) begin
                        r_sh_x    <= newLocX;
                        r_sh_y    <= newLocY;
                        r_sh_info <= newBotInfo;
                    end
                    if (w_tick && !w_xfer) begin
                        r_state     <= IDLE;
                        r_upd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_upd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ICON_BLINK_EN
    logic       r_committed;
    logic [7:0] r_blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_committed <= 1'b0;
            r_icon_en   <= 1'b0;
            r_blink_cnt <= '0;
        end else if (!r_committed) begin
            if (w_commit) begin
                r_committed <= 1'b1;
                r_icon_en   <= 1'b1;
                r_blink_cnt <= '0;
            end
        end else if (!info_alert(r_bot_info)) begin
            r_icon_en   <= 1'b1;
            r_blink_cnt <= '0;
        end else if (w_tick) begin
            if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_icon_en   <= !r_icon_en;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_FRAMES != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_icon_en <= 1'b0;
        else if (w_commit)
            r_icon_en <= 1'b1;
    end
`endif

    assign updReady   = r_upd_ready;
    assign locX       = r_loc_x;
    assign locY       = r_loc_y;
    assign botInfo    = r_bot_info;
    assign iconEnable = r_icon_en;
    assign frameTick  = w_tick;
    assign pending    = (r_state == PENDING);
endmodule

// File: tb/tb_icon_ctrl.sv
// Directed, table-driven bench for icon_ctrl (second instance with OVERWRITE=0).
module tb_icon_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixRow, pixCol;
    logic       updValid;
    logic [7:0] newLocX, newLocY, newBotInfo;

    logic       updReady, iconEnable, frameTick, pending;
    logic [7:0] locX, locY, botInfo, frameCount;
    logic       updReady0, iconEnable0, frameTick0, pending0;
    logic [7:0] locX0, locY0, botInfo0, frameCount0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icon_ctrl #(.COMMIT_ROW(480), .OVERWRITE(1), .BLINK_FRAMES(2)) u_dut (
        .clk(clk), .reset(reset), .pixRow(pixRow), .pixCol(pixCol),
        .updValid(updValid), .updReady(updReady),
        .newLocX(newLocX), .newLocY(newLocY), .newBotInfo(newBotInfo),
        .locX(locX), .locY(locY), .botInfo(botInfo), .iconEnable(iconEnable),
        .frameTick(frameTick), .frameCount(frameCount), .pending(pending)
    );

    icon_ctrl #(.COMMIT_ROW(480), .OVERWRITE(0), .BLINK_FRAMES(2)) u_dut0 (
        .clk(clk), .reset(reset), .pixRow(pixRow), .pixCol(pixCol),
        .updValid(updValid), .updReady(updReady0),
        .newLocX(newLocX), .newLocY(newLocY), .newBotInfo(newBotInfo),
        .locX(locX0), .locY(locY0), .botInfo(botInfo0), .iconEnable(iconEnable0),
        .frameTick(frameTick0), .frameCount(frameCount0), .pending(pending0)
    );

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic       vld;
        logic [7:0] x, y, info;
        logic       tick, rdy, pend, en;
        logic [7:0] lx, ly, li, fc;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input int row, input int col, input int vld,
                                input int x, input int y, input int info,
                                input int tick, input int rdy, input int pend, input int en,
                                input int lx, input int ly, input int li, input int fc);
        vec_t v;
        v.row = 10'(row); v.col = 10'(col); v.vld = 1'(vld);
        v.x = 8'(x); v.y = 8'(y); v.info = 8'(info);
        v.tick = 1'(tick); v.rdy = 1'(rdy); v.pend = 1'(pend); v.en = 1'(en);
        v.lx = 8'(lx); v.ly = 8'(ly); v.li = 8'(li); v.fc = 8'(fc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        pixRow = 10'd480; pixCol = 10'd0; step();
        pixRow = 10'd0;   pixCol = 10'd5; step();
    endtask

    initial begin
        //       row  col vld  x     y     info   tick rdy pend en  lx    ly    li    fc
        vt[0]  = mk(0,   5,  0, 'h00, 'h00, 'h00,  0,  1,  0,  0, 'h00, 'h00, 'h00, 0);
        vt[1]  = mk(0,   5,  1, 'h10, 'h22, 'h03,  0,  1,  1,  0, 'h00, 'h00, 'h00, 0);
        vt[2]  = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  1,  0, 'h00, 'h00, 'h00, 0);
        vt[3]  = mk(480, 1,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h10, 'h22, 'h03, 1);
        vt[4]  = mk(0,   5,  1, 'h05, 'h00, 'h00,  0,  1,  1,  1, 'h10, 'h22, 'h03, 1);
        vt[5]  = mk(0,   5,  1, 'h06, 'h07, 'h04,  0,  1,  1,  1, 'h10, 'h22, 'h03, 1);
        vt[6]  = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  1,  1, 'h10, 'h22, 'h03, 1);
        vt[7]  = mk(480, 0,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h06, 'h07, 'h04, 2);
        vt[8]  = mk(480, 0,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h06, 'h07, 'h04, 2);
        vt[9]  = mk(480, 0,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h06, 'h07, 'h04, 2);
        vt[10] = mk(0,   0,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h06, 'h07, 'h04, 2);
        vt[11] = mk(0,   5,  1, 'h30, 'h01, 'h01,  0,  1,  1,  1, 'h06, 'h07, 'h04, 2);
        vt[12] = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  1,  1, 'h06, 'h07, 'h04, 2);
        vt[13] = mk(480, 1,  1, 'h31, 'h02, 'h02,  0,  1,  1,  1, 'h30, 'h01, 'h01, 3);
        vt[14] = mk(0,   5,  0, 'h00, 'h00, 'h00,  0,  1,  1,  1, 'h30, 'h01, 'h01, 3);
        vt[15] = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  1,  1, 'h30, 'h01, 'h01, 3);
        vt[16] = mk(0,   3,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h31, 'h02, 'h02, 4);
        vt[17] = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  0,  1, 'h31, 'h02, 'h02, 4);
        vt[18] = mk(0,   5,  1, 'h40, 'h41, 'h05,  0,  1,  1,  1, 'h31, 'h02, 'h02, 5);
        vt[19] = mk(0,   5,  0, 'h00, 'h00, 'h00,  0,  1,  1,  1, 'h31, 'h02, 'h02, 5);
        vt[20] = mk(480, 0,  0, 'h00, 'h00, 'h00,  1,  1,  1,  1, 'h31, 'h02, 'h02, 5);
        vt[21] = mk(0,   5,  0, 'h00, 'h00, 'h00,  0,  1,  0,  1, 'h40, 'h41, 'h05, 6);

        reset = 1'b1; pixRow = '0; pixCol = 10'd5; updValid = 1'b0;
        newLocX = '0; newLocY = '0; newBotInfo = '0;
        step(); step();
        chk("rst.locX", locX, 0);
        chk("rst.iconEnable", iconEnable, 0);
        chk("rst.frameTick", frameTick, 0);
        chk("rst.frameCount", frameCount, 0);
        chk("rst.pending", pending, 0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            pixRow = vt[i].row; pixCol = vt[i].col; updValid = vt[i].vld;
            newLocX = vt[i].x; newLocY = vt[i].y; newBotInfo = vt[i].info;
            step();
            chk($sformatf("v%0d.frameTick", i), frameTick, vt[i].tick);
            chk($sformatf("v%0d.updReady", i), updReady, vt[i].rdy);
            chk($sformatf("v%0d.pending", i), pending, vt[i].pend);
            chk($sformatf("v%0d.iconEnable", i), iconEnable, vt[i].en);
            chk($sformatf("v%0d.locX", i), locX, vt[i].lx);
            chk($sformatf("v%0d.locY", i), locY, vt[i].ly);
            chk($sformatf("v%0d.botInfo", i), botInfo, vt[i].li);
            chk($sformatf("v%0d.frameCount", i), frameCount, vt[i].fc);
        end
        updValid = 1'b0;

        // Reset mid-PENDING discards the shadow
        updValid = 1'b1; newLocX = 8'h20; newLocY = 8'h21; newBotInfo = 8'h01;
        step();
        updValid = 1'b0;
        chk("midrst.pending_before", pending, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.locX", locX, 0);
        chk("midrst.locY", locY, 0);
        chk("midrst.botInfo", botInfo, 0);
        chk("midrst.iconEnable", iconEnable, 0);
        chk("midrst.frameCount", frameCount, 0);
        chk("midrst.pending", pending, 0);
        step();
        reset = 1'b0;
        pixRow = 10'd480; pixCol = 10'd0; step();
        chk("midrst.tick", frameTick, 1);
        pixRow = 10'd0; pixCol = 10'd5; step();
        chk("midrst.locX_after", locX, 0);
        chk("midrst.pending_after", pending, 0);
        chk("midrst.en_after", iconEnable, 0);

        // frameCount wrap: 1 frame done, 254 more -> 255, one more -> 0
        for (int f = 0; f < 254; f++) frame();
        chk("wrap.fc255", frameCount, 255);
        frame();
        chk("wrap.fc0", frameCount, 0);

        // OVERWRITE=0 instance blocks further updates while pending
        updValid = 1'b1; newLocX = 8'h55; newLocY = 8'h56; newBotInfo = 8'h02;
        step();
        chk("ovw0.ready_drop", updReady0, 0);
        chk("ovw0.pending", pending0, 1);
        newLocX = 8'h66;
        step();
        chk("ovw0.ready_held", updReady0, 0);
        updValid = 1'b0;
        pixRow = 10'd480; pixCol = 10'd0; step();
        chk("ovw0.tick", frameTick0, 1);
        chk("ovw0.ready_tick", updReady0, 0);
        pixRow = 10'd0; pixCol = 10'd5; step();
        chk("ovw0.locX", locX0, 8'h55);
        chk("ovw0.ready_back", updReady0, 1);
        chk("ovw0.pending_clr", pending0, 0);

`ifdef ICON_BLINK_EN
        reset = 1'b1; step(); reset = 1'b0;
        updValid = 1'b1; newLocX = 8'h01; newLocY = 8'h02; newBotInfo = 8'h80;
        step();
        updValid = 1'b0;
        frame();
        chk("blink.commit_en", iconEnable, 1);
        chk("blink.info", botInfo, 8'h80);
        frame(); chk("blink.f1", iconEnable, 1);
        frame(); chk("blink.f2", iconEnable, 0);
        frame(); chk("blink.f3", iconEnable, 0);
        frame(); chk("blink.f4", iconEnable, 1);
        updValid = 1'b1; newBotInfo = 8'h00;
        step();
        updValid = 1'b0;
        frame(); chk("blink.clr_f5", iconEnable, 1);
        frame(); chk("blink.clr_f6", iconEnable, 1);
        frame(); chk("blink.clr_f7", iconEnable, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
